lzy_key_debounce: RTL and testbench

- Upstream conditioning stage for the lab JK flip-flop blocks (74HC112-style).
- Converts a raw, bouncing, asynchronous push-button into clean synchronous signals:
  - a debounced level;
  - single-cycle press and release pulses.
- The press pulse is used as a clean clock/enable for the flip-flop stage.
- The debounced level drives its J/K inputs.

---
 rtl/lzy_key_debounce.sv | 183 ++++++++++++++++++
 tb/tb_lzy_key_debounce.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzy_key_debounce.sv
// -----------------------------------------------------------------------------
// lzy_key_debounce
//
// Purpose:
//   Conditions a raw, bouncing, asynchronous push-button for the JK flip-flop
//   lab stage. The button is brought into the Clk domain through a two-flop
//   synchronizer and normalized so that 1 means "pressed". A four-state FSM
//   then accepts a change only after the new level has been stable for
//   CNT_MAX+1 consecutive counted samples. All outputs are registered.
//
// Ports:
//   Clk          in   system clock, all logic on the rising edge
//   Rd           in   synchronous active-high reset
//   Key_in       in   raw button, asynchronous to Clk
//   Key_level    out  debounced state, 1 = pressed
//   Key_press    out  one-cycle pulse on an accepted press
//   Key_release  out  one-cycle pulse on an accepted release
//   Key_long     out  one-cycle long-press pulse (optional feature)
//
// Parameters:
//   CNT_MAX         stable-sample count (default 20 ms at 50 MHz)
//   KEY_ACTIVE_LOW  1 = raw key reads 0 when pressed
//   LONG_CNT        cycles spent in PRESSED before Key_long
//
// Configuration macro:
//   LZY_KEY_LONGPRESS_EN  when defined, builds the long-press counter and
//                         drives Key_long; otherwise Key_long is tied to 0.
// -----------------------------------------------------------------------------
module lzy_key_debounce #(
    parameter int CNT_MAX        = 999999,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int LONG_CNT       = 49999999
) (
    input  logic Clk,
    input  logic Rd,
    input  logic Key_in,
    output logic Key_level,
    output logic Key_press,
    output logic Key_release,
    output logic Key_long
);

    // CNT_MAX = 0 would give a zero-width counter; keep at least one bit.
    localparam int            CW       = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);
    localparam logic          REL_LVL  = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } state_t;

    logic [1:0]    r_sync;
    logic          w_key_s;
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_level_next;
    logic          w_press_next;
    logic          w_release_next;

    // Two-flop synchronizer; r_sync[1] is the first point where the key is
    // considered safe to use.
    always_ff @(posedge Clk) begin
        if (Rd) begin
            r_sync <= {REL_LVL, REL_LVL};
        end else begin
            r_sync <= {r_sync[0], Key_in};
        end
    end

    // Normalize polarity: 1 = pressed regardless of board wiring.
    assign w_key_s = r_sync[1] ^ REL_LVL;

    always_ff @(posedge Clk) begin
        if (Rd) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_key_s) begin
                    w_state_next = S_PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!w_key_s) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_PRESSED;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!w_key_s) begin
                    w_state_next = S_RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (w_key_s) begin
                    w_state_next = S_PRESSED;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // Outputs are computed from the next state so the registered
        // versions line up with the cycle the state itself changes.
        w_level_next   = (w_state_next == S_PRESSED) || (w_state_next == S_RELEASE_WAIT);
        w_press_next   = (r_state == S_PRESS_WAIT)   && (w_state_next == S_PRESSED);
        w_release_next = (r_state == S_RELEASE_WAIT) && (w_state_next == S_IDLE);
    end

    assign Key_level   = r_level;
    assign Key_press   = r_press;
    assign Key_release = r_release;

`ifdef LZY_KEY_LONGPRESS_EN
    localparam int            LW        = (LONG_CNT > 0) ? $clog2(LONG_CNT + 1) : 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT);

    logic [LW-1:0] r_long_cnt;
    logic          r_long_done;
    logic          r_long;

    // Counts only while sitting in PRESSED; any exit (including a release
    // bounce through RELEASE_WAIT) clears it so the count restarts.
    always_ff @(posedge Clk) begin
        if (Rd || (r_state != S_PRESSED)) begin
            r_long_cnt  <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end else if ((r_long_cnt == LONG_LAST) && !r_long_done) begin
            r_long_done <= 1'b1;
            r_long      <= 1'b1;
        end else begin
            r_long <= 1'b0;
            if (r_long_cnt != LONG_LAST) begin
                r_long_cnt <= r_long_cnt + 1'b1;
            end
        end
    end

    assign Key_long = r_long;
`else
    assign Key_long = 1'b0;
`endif

endmodule

// File: tb/tb_lzy_key_debounce.sv
module tb_lzy_key_debounce;

    localparam int CNT_MAX  = 4;
    localparam int LONG_CNT = 10;
    localparam int KAL      = 1;
    localparam int RUN_ACC  = CNT_MAX + 2;  // consecutive differing samples to flip
    localparam bit REL      = (KAL != 0);

    logic Clk    = 1'b0;
    logic Rd     = 1'b1;
    logic Key_in = 1'b1;
    logic Key_level, Key_press, Key_release, Key_long;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: raw delay line plus a run-length acceptance rule.
    bit m_d1 = 1'b1, m_d2 = 1'b1;
    bit m_level = 0, m_press = 0, m_rel = 0, m_long = 0;
    int m_run = 0;
    int m_pr  = 0;

    lzy_key_debounce #(
        .CNT_MAX        (CNT_MAX),
        .KEY_ACTIVE_LOW (KAL),
        .LONG_CNT       (LONG_CNT)
    ) dut (
        .Clk         (Clk),
        .Rd          (Rd),
        .Key_in      (Key_in),
        .Key_level   (Key_level),
        .Key_press   (Key_press),
        .Key_release (Key_release),
        .Key_long    (Key_long)
    );

    always #5 Clk = ~Clk;

    // Drive one cycle and advance the model; outputs sampled 1 time unit
    // after the edge.
    task automatic step(input bit key, input bit rd);
        bit ks, pst;
        Key_in = key;
        Rd     = rd;
        @(posedge Clk);
        cyc++;
        if (rd) begin
            m_d1 = REL; m_d2 = REL;
            m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
            m_run = 0; m_pr = 0;
        end else begin
            ks  = m_d2 ^ REL;
            pst = m_level && (m_run == 0);  // settled pressed, no release pending
            m_press = 0;
            m_rel   = 0;
            if (ks != m_level) begin
                m_run++;
                if (m_run == RUN_ACC) begin
                    m_level = ~m_level;
                    m_run   = 0;
                    m_press = m_level;
                    m_rel   = !m_level;
                end
            end else begin
                m_run = 0;
            end
            if (pst) begin
                if (m_pr < LONG_CNT + 2) m_pr++;
            end else begin
                m_pr = 0;
            end
`ifdef LZY_KEY_LONGPRESS_EN
            m_long = pst && (m_pr == LONG_CNT + 1);
`else
            m_long = 0;
`endif
            m_d2 = m_d1;
            m_d1 = key;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if ({Key_level, Key_press, Key_release, Key_long} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs cyc %0d got %b want 0000", cyc,
                     {Key_level, Key_press, Key_release, Key_long});
        end
        for (int e = 0; e < 20; e++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({Key_level, Key_press, Key_release, Key_long} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b want 0000", cyc,
                         {Key_level, Key_press, Key_release, Key_long});
            end
        end
        $display("test_reset done cyc %0d", cyc);
    endtask

    task automatic test_clean_press();
        for (int e = 0; e < 12; e++) begin
            step(1'b0, 1'b0);
            checks++;
            if ({Key_level, Key_press, Key_release} !== {(e >= 7), (e == 7), 1'b0} ||
                {Key_level, Key_press, Key_release, Key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL clean_press edge %0d got %b want lvl=%0d prs=%0d", e,
                         {Key_level, Key_press, Key_release, Key_long}, (e >= 7), (e == 7));
            end
        end
        for (int e = 0; e < 12; e++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({Key_level, Key_press, Key_release} !== {(e < 7), 1'b0, (e == 7)} ||
                {Key_level, Key_press, Key_release, Key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL clean_release edge %0d got %b want lvl=%0d rel=%0d", e,
                         {Key_level, Key_press, Key_release, Key_long}, (e < 7), (e == 7));
            end
        end
        $display("test_clean_press done cyc %0d", cyc);
    endtask

    task automatic test_press_bounce();
        bit pat [20];
        int presses = 0;
        for (int i = 0; i < 20; i++) pat[i] = (i == 3 || i == 4);
        for (int e = 0; e < 20; e++) begin
            step(pat[e], 1'b0);
            if (Key_press) presses++;
            checks++;
            if (Key_press !== (e == 12) ||
                {Key_level, Key_press, Key_release, Key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL press_bounce edge %0d got %b want prs=%0d model %b", e,
                         {Key_level, Key_press, Key_release, Key_long}, (e == 12),
                         {m_level, m_press, m_rel, m_long});
            end
        end
        checks++;
        if (presses != 1) begin
            errors++;
            $display("FAIL press_bounce_count got %0d want 1", presses);
        end
        for (int e = 0; e < 12; e++) step(1'b1, 1'b0);
        $display("test_press_bounce done cyc %0d presses %0d", cyc, presses);
    endtask

    task automatic test_release_bounce();
        for (int e = 0; e < 10; e++) step(1'b0, 1'b0);
        for (int e = 0; e < 14; e++) begin
            step((e < 2), 1'b0);
            checks++;
            if ({Key_level, Key_press, Key_release} !== 3'b100 ||
                {Key_level, Key_press, Key_release, Key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL release_bounce edge %0d got %b want 100x", e,
                         {Key_level, Key_press, Key_release, Key_long});
            end
        end
        for (int e = 0; e < 12; e++) step(1'b1, 1'b0);
        $display("test_release_bounce done cyc %0d", cyc);
    endtask

    task automatic test_mid_reset();
        int presses = 0;
        for (int e = 0; e < 6; e++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        checks++;
        if ({Key_level, Key_press, Key_release, Key_long} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b want 0000",
                     {Key_level, Key_press, Key_release, Key_long});
        end
        for (int e = 0; e < 12; e++) begin
            step(1'b0, 1'b0);
            if (Key_press) presses++;
            checks++;
            if ({Key_level, Key_press} !== {(e >= 7), (e == 7)} ||
                {Key_level, Key_press, Key_release, Key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL mid_reset_latency edge %0d got %b want lvl=%0d prs=%0d", e,
                         {Key_level, Key_press, Key_release, Key_long}, (e >= 7), (e == 7));
            end
        end
        checks++;
        if (presses != 1) begin
            errors++;
            $display("FAIL mid_reset_count got %0d want 1", presses);
        end
        for (int e = 0; e < 12; e++) step(1'b1, 1'b0);
        $display("test_mid_reset done cyc %0d", cyc);
    endtask

    task automatic test_long_press();
        int press_at = -1;
        int longs    = 0;
        int long_at  = -1;
        for (int e = 0; e < 30; e++) begin
            step(1'b0, 1'b0);
            if (Key_press) press_at = e;
            if (Key_long) begin longs++; long_at = e; end
            checks++;
            if ({Key_level, Key_press, Key_release, Key_long} !== {m_level, m_press, m_rel, m_long}) begin
                errors++;
                $display("FAIL long_press edge %0d got %b want %b", e,
                         {Key_level, Key_press, Key_release, Key_long},
                         {m_level, m_press, m_rel, m_long});
            end
        end
`ifdef LZY_KEY_LONGPRESS_EN
        checks++;
        if (longs != 1 || long_at - press_at != LONG_CNT + 1) begin
            errors++;
            $display("FAIL long_count got %0d pulses offset %0d want 1 offset %0d",
                     longs, long_at - press_at, LONG_CNT + 1);
        end
`else
        checks++;
        if (longs != 0) begin
            errors++;
            $display("FAIL long_disabled got %0d pulses want 0", longs);
        end
`endif
        for (int e = 0; e < 12; e++) step(1'b1, 1'b0);
        $display("test_long_press done cyc %0d press_at %0d longs %0d", cyc, press_at, longs);
    endtask

    task automatic test_random();
        bit key = 1'b1;
        int seg = 0;
        bit prev_p = 0, prev_r = 0;
        for (int e = 0; e < 800; e++) begin
            if (seg == 0) begin
                key = ~key;
                seg = $urandom_range(1, 12);
            end
            seg--;
            step(key, ($urandom_range(0, 149) == 0));
            checks++;
            if ({Key_level, Key_press, Key_release, Key_long} !== {m_level, m_press, m_rel, m_long} ||
                (Key_press && Key_release) || (Key_press && prev_p) || (Key_release && prev_r)) begin
                errors++;
                $display("FAIL random cyc %0d got %b want %b", cyc,
                         {Key_level, Key_press, Key_release, Key_long},
                         {m_level, m_press, m_rel, m_long});
            end
            prev_p = Key_press;
            prev_r = Key_release;
        end
        $display("test_random done cyc %0d", cyc);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_mid_reset();
        test_long_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
